// File: rtl/piece_move_gen.sv
// piece_move_gen: expands one source square into every pseudo-legal successor board over Avalon-MM
module piece_move_gen #(
    parameter int BOARD_DIM = 8,
    parameter int MAX_MOVES = 27,
    parameter int CNT_W     = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);
    localparam int NSQ = BOARD_DIM * BOARD_DIM;
    localparam int IDX_W = $clog2(NSQ);
    localparam logic [7:0] DIM8 = 8'(BOARD_DIM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSQ - 1);

    typedef enum logic [3:0] {
        IDLE, RD_SRC, WT_SRC, NEXT_DIR, STEP, RD_TGT, WT_TGT, RD_CP, WT_CP, WR_CP, DONE
    } state_t;

    state_t state_q, state_d;
    logic [31:0] src_addr_q, src_addr_d, dst_addr_q, dst_addr_d, src_x_q, src_x_d, src_y_q, src_y_d;
    logic [31:0] mode_q, mode_d, cap_q, cap_d, word_q, word_d;
    logic [7:0] src_pc_q, src_pc_d, cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [3:0] dir_q, dir_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic cont_q, cont_d, ovf_q, ovf_d;

    logic [2:0] m;
    logic mode_ok, slider, off_board, own, at_cap, cfg_wr, start, rd_unused;
    logic [3:0] n_dirs;
    logic [7:0] dx, dy, tx, ty, rd_pc;
    logic [31:0] src_sq, cur_sq, idx32, eff_cap, rd_ext, board_base;

    function automatic logic [31:0] sq_idx(input logic [7:0] x, input logic [7:0] y);
        return 32'(y) * BOARD_DIM + 32'(x);
    endfunction

    // {dx,dy}; queen order (rook rays then bishop rays) also serves king, rook and bishop
    function automatic logic [15:0] dir_delta(input logic [2:0] md, input logic [3:0] i);
        logic [2:0] k;
        logic [15:0] r;
        k = (md == 3'd3) ? {1'b1, i[1:0]} : i[2:0];
        r = '0;
        if (md == 3'd0)
            case (i[2:0])
                3'd0: r = {8'h01, 8'h02};
                3'd1: r = {8'hFF, 8'h02};
                3'd2: r = {8'h01, 8'hFE};
                3'd3: r = {8'hFF, 8'hFE};
                3'd4: r = {8'h02, 8'h01};
                3'd5: r = {8'hFE, 8'h01};
                3'd6: r = {8'h02, 8'hFF};
                3'd7: r = {8'hFE, 8'hFF};
            endcase
        else
            case (k)
                3'd0: r = {8'h01, 8'h00};
                3'd1: r = {8'hFF, 8'h00};
                3'd2: r = {8'h00, 8'h01};
                3'd3: r = {8'h00, 8'hFF};
                3'd4: r = {8'h01, 8'h01};
                3'd5: r = {8'h01, 8'hFF};
                3'd6: r = {8'hFF, 8'h01};
                3'd7: r = {8'hFF, 8'hFF};
            endcase
        return r;
    endfunction

    assign rd_unused = ^master_readdata[31:8];

    // Move geometry, target classification and cap bookkeeping
    always_comb begin
        m = mode_q[2:0];
        mode_ok = mode_q < 32'd5;
        slider = mode_ok && m >= 3'd2;
        n_dirs = !mode_ok ? 4'd0 : (m == 3'd2 || m == 3'd3) ? 4'd4 : 4'd8;
        {dx, dy} = dir_delta(m, dir_q);
        tx = cur_x_q + dx;
        ty = cur_y_q + dy;
        // negative coordinates have bit 7 set, so an unsigned compare also rejects them
        off_board = tx >= DIM8 || ty >= DIM8;
        src_sq = sq_idx(src_x_q[7:0], src_y_q[7:0]);
        cur_sq = sq_idx(cur_x_q, cur_y_q);
        idx32 = 32'(idx_q);
        rd_pc = master_readdata[7:0];
        rd_ext = {{24{rd_pc[7]}}, rd_pc};
        own = rd_pc != 8'd0 && rd_pc[7] == src_pc_q[7];
        eff_cap = (cap_q == 32'd0 || cap_q > 32'(MAX_MOVES)) ? 32'(MAX_MOVES) : cap_q;
        at_cap = 32'(count_q) == eff_cap;
        board_base = dst_addr_q + 32'(count_q) * 32'(4 * NSQ);
        cfg_wr = slave_write && (state_q == IDLE || state_q == DONE);
        start = cfg_wr && slave_address == 4'd0;
    end

    // Bus outputs are decoded from the registered state so they stay stable under waitrequest
    always_comb begin
        master_read = state_q == RD_SRC || state_q == RD_TGT || state_q == RD_CP;
        master_write = state_q == WR_CP;
        master_address = state_q == RD_SRC ? src_addr_q + (src_sq << 2) :
                         state_q == RD_TGT ? src_addr_q + (cur_sq << 2) :
                         state_q == RD_CP  ? src_addr_q + (idx32 << 2) :
                         state_q == WR_CP  ? board_base + (idx32 << 2) : '0;
        master_writedata = master_write ? word_q : '0;
        slave_waitrequest = slave_read && slave_address == 4'd0 && state_q != IDLE && state_q != DONE;
    end

    // CPU register read mux
    always_comb begin
        case (slave_address)
            4'd0: slave_readdata = {ovf_q, {(31 - CNT_W){1'b0}}, count_q};
            4'd1: slave_readdata = src_addr_q;
            4'd2: slave_readdata = dst_addr_q;
            4'd3: slave_readdata = src_x_q;
            4'd4: slave_readdata = src_y_q;
            4'd5: slave_readdata = mode_q;
            4'd6: slave_readdata = cap_q;
            default: slave_readdata = '0;
        endcase
    end

    // Configuration writes and the move-walking / board-copy FSM
    always_comb begin
        state_d = state_q;
        src_addr_d = src_addr_q;
        dst_addr_d = dst_addr_q;
        src_x_d = src_x_q;
        src_y_d = src_y_q;
        mode_d = mode_q;
        cap_d = cap_q;
        word_d = word_q;
        src_pc_d = src_pc_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        dir_d = dir_q;
        idx_d = idx_q;
        count_d = count_q;
        cont_d = cont_q;
        ovf_d = ovf_q;
        if (cfg_wr)
            case (slave_address)
                4'd1: src_addr_d = slave_writedata;
                4'd2: dst_addr_d = slave_writedata;
                4'd3: src_x_d = slave_writedata;
                4'd4: src_y_d = slave_writedata;
                4'd5: mode_d = slave_writedata;
                4'd6: cap_d = slave_writedata;
                default: ;
            endcase
        case (state_q)
            IDLE: ;
            RD_SRC: if (!master_waitrequest) state_d = WT_SRC;
            WT_SRC: if (master_readdatavalid) begin
                src_pc_d = rd_pc;
                state_d = rd_pc == 8'd0 ? DONE : NEXT_DIR;
            end
            NEXT_DIR: if (dir_q >= n_dirs) state_d = DONE;
            else begin
                cur_x_d = src_x_q[7:0];
                cur_y_d = src_y_q[7:0];
                state_d = STEP;
            end
            STEP: if (off_board) begin
                dir_d = dir_q + 4'd1;
                state_d = NEXT_DIR;
            end else begin
                cur_x_d = tx;
                cur_y_d = ty;
                state_d = RD_TGT;
            end
            RD_TGT: if (!master_waitrequest) state_d = WT_TGT;
            WT_TGT: if (master_readdatavalid) begin
                if (own) begin
                    dir_d = dir_q + 4'd1;
                    state_d = NEXT_DIR;
                end else if (at_cap) begin
                    ovf_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cont_d = slider && rd_pc == 8'd0;
                    idx_d = '0;
                    state_d = RD_CP;
                end
            end
            RD_CP: if (!master_waitrequest) state_d = WT_CP;
            WT_CP: if (master_readdatavalid) begin
                word_d = idx32 == cur_sq ? {{24{src_pc_q[7]}}, src_pc_q} : idx32 == src_sq ? '0 : rd_ext;
                state_d = WR_CP;
            end
            WR_CP: if (!master_waitrequest) begin
                if (idx_q == LAST_IDX) begin
                    count_d = count_q + CNT_W'(1);
                    dir_d = cont_q ? dir_q : dir_q + 4'd1;
                    state_d = cont_q ? STEP : NEXT_DIR;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    state_d = RD_CP;
                end
            end
            DONE: if (slave_read && slave_address == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = RD_SRC;
            count_d = '0;
            ovf_d = 1'b0;
            dir_d = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_addr_q <= '0;
            dst_addr_q <= '0;
            src_x_q <= '0;
            src_y_q <= '0;
            mode_q <= '0;
            cap_q <= '0;
            word_q <= '0;
            src_pc_q <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            dir_q <= '0;
            idx_q <= '0;
            count_q <= '0;
            cont_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_addr_q <= src_addr_d;
            dst_addr_q <= dst_addr_d;
            src_x_q <= src_x_d;
            src_y_q <= src_y_d;
            mode_q <= mode_d;
            cap_q <= cap_d;
            word_q <= word_d;
            src_pc_q <= src_pc_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            dir_q <= dir_d;
            idx_q <= idx_d;
            count_q <= count_d;
            cont_q <= cont_d;
            ovf_q <= ovf_d;
        end
    end
endmodule
